stopwatch_seg_scan: RTL and testbench
=====================================

# stopwatch_seg_scan

Multiplexed 4-digit 7-segment display driver for the stopwatch. It reads the four BCD time digits and the `time_out` flag produced by the stopwatch control block. It scans them onto a common-anode display (SS.mm format) with frame-synchronous snapshotting, inter-digit dead time, leading-zero blanking and a timeout blink. It sits between the control block and the board's segment/anode pins.

## Interface
Parameters:
- `SCAN_DIV`, 4: `clk_1khz` cycles per digit slot; must be ≥ 2.
- `BLINK_HALF`, 250: `clk_1khz` cycles per blink half-period (2 Hz at 1 kHz).

Ports (one clock, `clk_1khz`; reset `rst` is asynchronous and active-high):
- `clk_1khz`  in  1  scan clock.
- `rst`  in  1  asynchronous, active-high reset.
- `time_sec_h`  in  3  seconds tens digit (0–5).
- `time_sec_l`  in  4  seconds units digit (BCD).
- `time_msec_h`  in  4  tenths digit (BCD).
- `time_msec_l`  in  4  hundredths digit (BCD).
- `time_out`  in  1  timeout flag; high = blink display.
- `seg`  out  7  segments, active-low; bit0 = a … bit6 = g.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  digit enables, active-low; an[0] = hundredths … an[3] = seconds tens.

## Operation
- Slot divider `div` counts 0..SCAN_DIV-1 and wraps. Digit index `idx` (0..3) advances by 1 when `div == SCAN_DIV-1`, and wraps 3→0.
- Slot mapping: idx0 = time_msec_l, idx1 = time_msec_h, idx2 = time_sec_l, idx3 = time_sec_h.
  - time_sec_h is zero-extended to 4 bits.
- Snapshot: on the edge where `div == SCAN_DIV-1` and `idx == 3`, all four inputs are latched into shadow registers. Only shadows are displayed, so there is no tearing within a frame.
  - Shadows reset to 0.
- Dead time: while `div == 0`, `an = 4'b1111`, `seg = 7'h7F` and `dp = 1`.
- Active slot (`div != 0`): `an = ~(4'b0001 << idx)`.
  - `seg` = decode(shadow[idx]).
  - `dp = 0` only when idx == 2; otherwise 1.
- Decode (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - 10–15 = 0111111 (dash).
- Leading-zero blank: in slot idx3, if shadow sec_h == 0 then `an[3]` stays 1 and `seg = 7'h7F`.
- Blink FSM, two states, ON and OFF:
  - While `time_out == 0`: state is forced to ON and the blink counter is held at 0.
  - While `time_out == 1`: the counter counts 0..BLINK_HALF-1. At terminal count the state toggles and the counter returns to 0.
  - In OFF, `an = 4'b1111` and `seg/dp` are all ones, regardless of slot.
  - Scan and snapshot keep running during OFF.
- Priority, highest first: reset, blink OFF, dead time, leading-zero blank, normal drive.

## Timing
- Reset values: `an = 4'b1111`, `seg = 7'h7F`, `dp = 1`, div = 0, idx = 0, shadows = 0, blink state ON, blink counter = 0.
  - Reset takes effect immediately on `rst` assertion, including mid-slot.
- All outputs are registered. Outputs at edge k+1 reflect div/idx/shadow/blink state after edge k, giving 1-cycle output latency.
- Frame length is 4·SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles, preceded by 1 dead cycle.
- Input-to-display latency: a change is latched at the next frame boundary. It appears in slot idx0 one cycle after that slot's dead cycle. Worst case is 4·SCAN_DIV+2 cycles.
- Input change on the snapshot edge itself: the value sampled on that edge is used.
- `time_out` falling: blink state is ON at the next edge, so the display is restored within 1 cycle (output register latency).
- `time_out` rising: the first OFF phase begins BLINK_HALF cycles later. The display stays lit until then.

## Test plan
- Reset: assert `rst` mid-frame → `an = 1111`, `seg = 7'h7F`, `dp = 1` with no clock edge. After release, frame 1 shows 0.00 with an[3] blanked.
- Static 59.99, SCAN_DIV = 4: `an` repeats 1111, 1110×3, 1111, 1101×3, 1111, 1011×3, 1111, 0111×3.
  - `seg` = 0010000 in slots 0–2 and 0010010 in slot 3.
  - `dp = 0` only during the 1011 cycles.
- Anti-tearing: show 12.34, then change inputs to 56.78 while idx = 1 → remaining slots of that frame still show 12.34. The next frame shows 56.78.
- Leading zero: inputs 0.07 → the idx3 slot keeps `an = 1111`. The idx0 slot shows `seg = 1111000`.
- Blink, with BLINK_HALF = 8: hold `time_out = 1` for 40 cycles → display alternates 8 cycles lit / 8 cycles dark (`an = 1111`). Drop `time_out` while dark → normal drive resumes 1 cycle later.
- Invalid BCD: `time_msec_l = 4'hC` → `seg = 0111111` during the idx0 slot. Other slots are unaffected.

Source files
------------

// File: rtl/stopwatch_seg_scan.sv
// stopwatch_seg_scan
//   Drives a common-anode 4-digit 7-segment display in SS.mm format from the
//   stopwatch BCD digits. One digit slot lasts SCAN_DIV clocks. The first clock
//   of every slot is dark so that the anodes do not ghost. Digits are
//   snapshotted once per frame, so a frame never shows a mix of old and new
//   time. A leading seconds-tens zero is blanked. The whole display blinks
//   while time_out is high.
//
// Ports
//   clk_1khz     in   1  scan clock
//   rst          in   1  asynchronous active-high reset
//   time_sec_h   in   3  seconds tens digit (0-5)
//   time_sec_l   in   4  seconds units digit (BCD)
//   time_msec_h  in   4  tenths digit (BCD)
//   time_msec_l  in   4  hundredths digit (BCD)
//   time_out     in   1  timeout flag, high = blink display
//   seg          out  7  segments, active-low, bit0 = a .. bit6 = g
//   dp           out  1  decimal point, active-low
//   an           out  4  digit enables, active-low, an[0] = hundredths
module stopwatch_seg_scan #(
   parameter int unsigned SCAN_DIV   = 4,
   parameter int unsigned BLINK_HALF = 250
) (
   input  logic       clk_1khz,
   input  logic       rst,
   input  logic [2:0] time_sec_h,
   input  logic [3:0] time_sec_l,
   input  logic [3:0] time_msec_h,
   input  logic [3:0] time_msec_l,
   input  logic       time_out,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
   localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   typedef enum logic {
      BLINK_ON  = 1'b0,
      BLINK_OFF = 1'b1
   } blink_e;

   // Segment pattern, active-low, ordered g..a. Non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // Scan position
   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         idx_q, idx_d;

   // Per-frame digit snapshot: [0] hundredths .. [3] seconds tens
   logic [3:0][3:0]    shadow_q, shadow_d;

   // Blink state
   blink_e             blink_q, blink_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

   // Registered pin drivers
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic [3:0]         an_q, an_d;

   logic               slot_end;
   logic [3:0]         digit;

   assign slot_end = (div_q == DIV_LAST);
   assign digit    = shadow_q[idx_q];

   // Scan divider, digit index and frame snapshot
   always_comb begin
      div_d    = div_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (slot_end) begin
         div_d = '0;
         idx_d = idx_q + 2'd1;
         // Latch only at the frame boundary so a frame never tears
         if (idx_q == 2'd3) begin
            shadow_d[0] = time_msec_l;
            shadow_d[1] = time_msec_h;
            shadow_d[2] = time_sec_l;
            shadow_d[3] = {1'b0, time_sec_h};
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Blink FSM: held in ON with a cleared counter while time_out is low,
   // so the first dark phase starts a full half-period after time_out rises
   always_comb begin
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      if (!time_out) begin
         blink_d     = BLINK_ON;
         blink_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_d     = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         blink_cnt_d = '0;
      end else begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
   end

   // Output drive, from the current scan/blink state; registered below.
   // Priority: blink dark, dead cycle, leading-zero blank, normal digit.
   always_comb begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
      if (blink_q == BLINK_OFF) begin
         an_d  = '1;
      end else if (div_q == '0) begin
         an_d  = '1;
      end else if ((idx_q == 2'd3) && (digit == 4'd0)) begin
         an_d  = '1;
      end else begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = seg_decode(digit);
         dp_d  = (idx_q != 2'd2);
      end
   end

   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         blink_q     <= BLINK_ON;
         blink_cnt_q <= '0;
         seg_q       <= '1;
         dp_q        <= 1'b1;
         an_q        <= '1;
      end else begin
         div_q       <= div_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
module tb_stopwatch_seg_scan;

   logic       clk_1khz;
   logic       rst;
   logic [2:0] time_sec_h;
   logic [3:0] time_sec_l;
   logic [3:0] time_msec_h;
   logic [3:0] time_msec_l;
   logic       time_out;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int n_vec;
   int n_err;

   stopwatch_seg_scan #(
      .SCAN_DIV   (4),
      .BLINK_HALF (8)
   ) dut (
      .clk_1khz    (clk_1khz),
      .rst         (rst),
      .time_sec_h  (time_sec_h),
      .time_sec_l  (time_sec_l),
      .time_msec_h (time_msec_h),
      .time_msec_l (time_msec_l),
      .time_out    (time_out),
      .seg         (seg),
      .dp          (dp),
      .an          (an)
   );

   initial begin
      clk_1khz = 1'b0;
      forever #5 clk_1khz = ~clk_1khz;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Hand-written active-low patterns, g..a
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Expected {an, dp, seg} at frame position p (0..15) for digits shown
   function automatic logic [11:0] exp_out(input logic [15:0] shown, input int p, input bit dark);
      int         slot;
      int         sub;
      logic [3:0] d;
      logic [3:0] a;
      slot = p / 4;
      sub  = p % 4;
      d    = shown[slot*4 +: 4];
      if (dark || sub == 0 || (slot == 3 && d == 4'd0))
         return {4'b1111, 1'b1, 7'h7F};
      a = 4'b1111;
      a[slot] = 1'b0;
      return {a, (slot == 2) ? 1'b0 : 1'b1, seg_of(d)};
   endfunction

   task automatic set_in(input logic [15:0] v);
      time_sec_h  = v[14:12];
      time_sec_l  = v[11:8];
      time_msec_h = v[7:4];
      time_msec_l = v[3:0];
   endtask

   task automatic step_chk(input logic [15:0] shown, input int p, input bit dark, input string what);
      logic [11:0] e;
      @(posedge clk_1khz);
      @(negedge clk_1khz);
      e = exp_out(shown, p, dark);
      chk($sformatf("%s p%0d an", what, p), {28'd0, an}, {28'd0, e[11:8]});
      chk($sformatf("%s p%0d dp", what, p), {31'd0, dp}, {31'd0, e[7]});
      chk($sformatf("%s p%0d seg", what, p), {25'd0, seg}, {25'd0, e[6:0]});
   endtask

   // One full 16-cycle frame; inputs switch to new_in just before position chg_p
   task automatic run_frame(input logic [15:0] shown, input int chg_p, input logic [15:0] new_in,
                            input string what);
      for (int p = 0; p < 16; p++) begin
         if (p == chg_p) set_in(new_in);
         step_chk(shown, p, 1'b0, what);
      end
   endtask

   task automatic chk_reset_out(input string what);
      chk({what, " an"}, {28'd0, an}, 32'hF);
      chk({what, " dp"}, {31'd0, dp}, 32'h1);
      chk({what, " seg"}, {25'd0, seg}, 32'h7F);
   endtask

   initial begin
      bit dark;
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b0;
      time_out = 1'b0;
      set_in(16'h0000);

      // Asynchronous reset, no clock edge yet
      #2 rst = 1'b1;
      #1 chk_reset_out("rst async");
      @(negedge clk_1khz);
      @(negedge clk_1khz);
      chk_reset_out("rst held");
      rst = 1'b0;

      // Frame 1: shadows still zero -> 0.00 with seconds tens blanked
      run_frame(16'h0000, 0, 16'h5999, "zero");
      // Frame 2: static 59.99; 12.34 arrives mid-frame for the next snapshot
      run_frame(16'h5999, 8, 16'h1234, "5999");
      // Frame 3: 12.34; inputs move to 56.78 during idx1 -> no tearing
      run_frame(16'h1234, 5, 16'h5678, "tear");
      run_frame(16'h5678, 3, 16'h0007, "5678");
      // Leading zero: 0.07
      run_frame(16'h0007, 0, 16'h123C, "lz");
      // Invalid BCD in hundredths -> dash in slot 0 only
      run_frame(16'h123C, 0, 16'h5999, "bcd");

      // Blink: lit 8 / dark 8 from time_out rising; dropped while dark at rel 45
      time_out = 1'b1;
      for (int rel = 1; rel <= 48; rel++) begin
         if (rel == 45) time_out = 1'b0;
         dark = (rel >= 9 && rel <= 16) || (rel >= 25 && rel <= 32) || (rel >= 41 && rel <= 45);
         step_chk(16'h5999, (rel - 1) % 16, dark, "blink");
      end
      run_frame(16'h5999, -1, 16'h0000, "post");

      // Mid-frame reset while digit 1 is lit
      for (int p = 0; p < 6; p++) step_chk(16'h5999, p, 1'b0, "pre");
      #2 rst = 1'b1;
      #1 chk_reset_out("rst mid");
      @(negedge clk_1khz);
      chk_reset_out("rst mid held");
      rst = 1'b0;
      run_frame(16'h0000, -1, 16'h0000, "after rst");
      run_frame(16'h5999, -1, 16'h0000, "after rst2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
